fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 152 +++++++++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding-request instruction fetcher.
//
// Walks a 16-bit byte-addressed pc in steps of 2, issuing one request
// at a time to instruction memory and presenting each fetched word to
// decode until it is consumed. Redirects (taken branch/jump) replace
// the pc; a request already in flight when a redirect arrives is
// completed and its data thrown away. Opcode 5'b00000 halts fetching
// until reset.
//
// Handshakes:
//   imem_req/imem_ready: imem_req stays high, with imem_addr stable,
//     until imem_ready is seen. imem_ready is a one-cycle strobe that
//     completes the request, and imem_rdata is sampled only on that
//     cycle.
//   instr_valid/dec_stall: an instruction is consumed on a clock edge
//     where instr_valid=1 and dec_stall=0.
//
// Ports:
//   clk, rst           clock, async active-high reset
//   imem_req/addr      request to instruction memory
//   imem_rdata/ready   completion from instruction memory
//   dec_stall          decode back-pressure
//   br_ju_en/target    redirect request
//   instr_out/valid/pc instruction presented to decode
//   pc_plus2           instr_pc + 2 (wraps)
//   halted             HALT consumed
//   err                sticky protocol/alignment error
//   dbg_state          current FSM state, for observation
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        dec_stall,
  input  logic        br_ju_en,
  input  logic [15:0] br_target,
  output logic [15:0] instr_out,
  output logic        instr_valid,
  output logic [15:0] instr_pc,
  output logic [15:0] pc_plus2,
  output logic        halted,
  output logic        err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_VALID  = 2'd1,
    ST_SQUASH = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  localparam logic [15:0] NOP_WORD = 16'h0800;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] sq_addr_q, sq_addr_d;   // address of the abandoned request
  logic [15:0] instr_q, instr_d;
  logic [15:0] instr_pc_q, instr_pc_d;
  logic        err_q, err_d;

  logic        req_state;
  logic [15:0] tgt_aligned;

  assign tgt_aligned = {br_target[15:1], 1'b0};
  assign req_state   = (state_q == ST_FETCH) || (state_q == ST_SQUASH);

  // Outputs are a function of state only, so they never depend
  // combinationally on memory or decode inputs.
  assign imem_req    = req_state && !rst;
  assign imem_addr   = (state_q == ST_SQUASH) ? sq_addr_q : pc_q;
  assign instr_out   = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc_plus2    = instr_pc_q + 16'd2;
  assign instr_valid = (state_q == ST_VALID);
  assign halted      = (state_q == ST_HALT);
  assign err         = err_q;
  assign dbg_state   = state_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    sq_addr_d  = sq_addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    err_d      = err_q;

    // A completion strobe with no request outstanding is a protocol error.
    if (imem_ready && !req_state) err_d = 1'b1;
    // Misaligned redirects are flagged but still taken (bit0 dropped);
    // HALT ignores redirects entirely.
    if (br_ju_en && br_target[0] && (state_q != ST_HALT)) err_d = 1'b1;

    case (state_q)
      ST_FETCH: begin
        if (br_ju_en) begin
          pc_d = tgt_aligned;
          if (!imem_ready) begin
            // Request must still complete at the old address.
            sq_addr_d = pc_q;
            state_d   = ST_SQUASH;
          end
        end else if (imem_ready) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          pc_d       = pc_q + 16'd2;
          state_d    = ST_VALID;
        end
      end
      ST_VALID: begin
        if (br_ju_en) begin
          pc_d    = tgt_aligned;
          state_d = ST_FETCH;
        end else if (!dec_stall) begin
          state_d = (instr_q[15:11] == 5'b00000) ? ST_HALT : ST_FETCH;
        end
      end
      ST_SQUASH: begin
        // Later redirects overwrite the earlier target.
        if (br_ju_en) pc_d = tgt_aligned;
        if (imem_ready) state_d = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= 16'h0000;
      sq_addr_q  <= 16'h0000;
      instr_q    <= NOP_WORD;
      instr_pc_q <= 16'h0000;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      sq_addr_q  <= sq_addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic        dec_stall;
  logic        br_ju_en;
  logic [15:0] br_target;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic [15:0] instr_pc;
  logic [15:0] pc_plus2;
  logic        halted;
  logic        err;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_pass;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .dec_stall  (dec_stall),
    .br_ju_en   (br_ju_en),
    .br_target  (br_target),
    .instr_out  (instr_out),
    .instr_valid(instr_valid),
    .instr_pc   (instr_pc),
    .pc_plus2   (pc_plus2),
    .halted     (halted),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic [15:0] rdata;
    logic        stall;
    logic        br;
    logic [15:0] tgt;
    logic        req;
    logic [15:0] addr;
    logic        vld;
    logic [15:0] iout;
    logic [15:0] ipc;
    logic [15:0] p2;
    logic        halt;
    logic        e;
  } vec_t;

  localparam int NV = 38;
  vec_t tbl [NV];

  function automatic vec_t mk(logic rdy, logic [15:0] rdata, logic stall, logic br,
                              logic [15:0] tgt, logic req, logic [15:0] addr, logic vld,
                              logic [15:0] iout, logic [15:0] ipc, logic [15:0] p2,
                              logic halt, logic e);
    vec_t v;
    v.rdy = rdy; v.rdata = rdata; v.stall = stall; v.br = br; v.tgt = tgt;
    v.req = req; v.addr = addr; v.vld = vld; v.iout = iout; v.ipc = ipc;
    v.p2 = p2; v.halt = halt; v.e = e;
    return v;
  endfunction

  // scoreboard helper
  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic drive(input logic rdy, input logic [15:0] rdata, input logic stall,
                       input logic br, input logic [15:0] tgt);
    imem_ready = rdy; imem_rdata = rdata; dec_stall = stall;
    br_ju_en = br; br_target = tgt;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk("imem_req", i, {15'd0, imem_req}, {15'd0, v.req});
    if (v.req) chk("imem_addr", i, imem_addr, v.addr);
    chk("instr_valid", i, {15'd0, instr_valid}, {15'd0, v.vld});
    chk("instr_out", i, instr_out, v.iout);
    chk("instr_pc", i, instr_pc, v.ipc);
    chk("pc_plus2", i, pc_plus2, v.p2);
    chk("halted", i, {15'd0, halted}, {15'd0, v.halt});
    chk("err", i, {15'd0, err}, {15'd0, v.e});
  endtask

  task automatic wait_req(input int budget, input string name);
    int n;
    n = 0;
    while (!imem_req && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    n_checks++;
    if (imem_req) n_pass++;
    else $display("FAIL %s: imem_req not seen within %0d cycles", name, budget);
  endtask

  initial begin
    vec_t v;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    drive(1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000);

    // fields: rdy rdata stall br tgt | req addr vld iout ipc p2 halt err
    tbl[0]  = mk(1, 16'h4123, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0800, 16'h0000, 16'h0002, 0, 0);
    tbl[1]  = mk(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h4123, 16'h0000, 16'h0002, 0, 0);
    tbl[2]  = mk(1, 16'h5555, 0, 0, 16'h0000, 1, 16'h0002, 0, 16'h4123, 16'h0000, 16'h0002, 0, 0);
    for (int i = 3; i <= 7; i++)
      tbl[i] = mk(0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h5555, 16'h0002, 16'h0004, 0, 0);
    tbl[8]  = mk(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h5555, 16'h0002, 16'h0004, 0, 0);
    tbl[9]  = mk(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0004, 0, 16'h5555, 16'h0002, 16'h0004, 0, 0);
    tbl[10] = mk(1, 16'h6001, 0, 0, 16'h0000, 1, 16'h0004, 0, 16'h5555, 16'h0002, 16'h0004, 0, 0);
    tbl[11] = mk(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h6001, 16'h0004, 16'h0006, 0, 0);
    tbl[12] = mk(0, 16'h0000, 0, 1, 16'h0100, 1, 16'h0006, 0, 16'h6001, 16'h0004, 16'h0006, 0, 0);
    tbl[13] = mk(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0006, 0, 16'h6001, 16'h0004, 16'h0006, 0, 0);
    tbl[14] = mk(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0006, 0, 16'h6001, 16'h0004, 16'h0006, 0, 0);
    tbl[15] = mk(1, 16'hDEAD, 0, 0, 16'h0000, 1, 16'h0006, 0, 16'h6001, 16'h0004, 16'h0006, 0, 0);
    tbl[16] = mk(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0100, 0, 16'h6001, 16'h0004, 16'h0006, 0, 0);
    tbl[17] = mk(1, 16'h7777, 0, 0, 16'h0000, 1, 16'h0100, 0, 16'h6001, 16'h0004, 16'h0006, 0, 0);
    // redirect beats stall in VALID
    tbl[18] = mk(0, 16'h0000, 1, 1, 16'h0200, 0, 16'h0000, 1, 16'h7777, 16'h0100, 16'h0102, 0, 0);
    // redirect with same-cycle ready in FETCH: data dropped, stay in FETCH
    tbl[19] = mk(1, 16'h0000, 0, 1, 16'h0300, 1, 16'h0200, 0, 16'h7777, 16'h0100, 16'h0102, 0, 0);
    tbl[20] = mk(1, 16'h1111, 0, 0, 16'h0000, 1, 16'h0300, 0, 16'h7777, 16'h0100, 16'h0102, 0, 0);
    tbl[21] = mk(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h1111, 16'h0300, 16'h0302, 0, 0);
    // two redirects during squash: last one wins
    tbl[22] = mk(0, 16'h0000, 0, 1, 16'h0400, 1, 16'h0302, 0, 16'h1111, 16'h0300, 16'h0302, 0, 0);
    tbl[23] = mk(0, 16'h0000, 0, 1, 16'h0500, 1, 16'h0302, 0, 16'h1111, 16'h0300, 16'h0302, 0, 0);
    tbl[24] = mk(1, 16'hBEEF, 0, 0, 16'h0000, 1, 16'h0302, 0, 16'h1111, 16'h0300, 16'h0302, 0, 0);
    tbl[25] = mk(0, 16'h0000, 0, 1, 16'hFFFE, 1, 16'h0500, 0, 16'h1111, 16'h0300, 16'h0302, 0, 0);
    tbl[26] = mk(1, 16'h0000, 0, 0, 16'h0000, 1, 16'h0500, 0, 16'h1111, 16'h0300, 16'h0302, 0, 0);
    // wrap at 0xFFFE
    tbl[27] = mk(1, 16'h1234, 0, 0, 16'h0000, 1, 16'hFFFE, 0, 16'h1111, 16'h0300, 16'h0302, 0, 0);
    tbl[28] = mk(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h1234, 16'hFFFE, 16'h0000, 0, 0);
    tbl[29] = mk(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h1234, 16'hFFFE, 16'h0000, 0, 0);
    // misaligned redirect
    tbl[30] = mk(0, 16'h0000, 0, 1, 16'h0101, 1, 16'h0000, 0, 16'h1234, 16'hFFFE, 16'h0000, 0, 0);
    tbl[31] = mk(1, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h1234, 16'hFFFE, 16'h0000, 0, 1);
    // HALT word fetched at 0x0100, then consumed
    tbl[32] = mk(1, 16'h0000, 0, 0, 16'h0000, 1, 16'h0100, 0, 16'h1234, 16'hFFFE, 16'h0000, 0, 1);
    tbl[33] = mk(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 16'h0100, 16'h0102, 0, 1);
    tbl[34] = mk(0, 16'h0000, 0, 1, 16'h0200, 0, 16'h0000, 0, 16'h0000, 16'h0100, 16'h0102, 1, 1);
    tbl[35] = mk(0, 16'h0000, 0, 1, 16'h0300, 0, 16'h0000, 0, 16'h0000, 16'h0100, 16'h0102, 1, 1);
    tbl[36] = mk(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0100, 16'h0102, 1, 1);
    tbl[37] = mk(0, 16'h0000, 0, 1, 16'h0600, 0, 16'h0000, 0, 16'h0000, 16'h0100, 16'h0102, 1, 1);

    // reset values, with a stray imem_ready during reset
    @(negedge clk); @(negedge clk); #1;
    chk("rst_req", 0, {15'd0, imem_req}, 16'd0);
    chk("rst_valid", 0, {15'd0, instr_valid}, 16'd0);
    chk("rst_instr", 0, instr_out, 16'h0800);
    chk("rst_pc", 0, instr_pc, 16'h0000);
    chk("rst_p2", 0, pc_plus2, 16'h0002);
    chk("rst_halted", 0, {15'd0, halted}, 16'd0);
    chk("rst_err", 0, {15'd0, err}, 16'd0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NV; i++) begin
      v = tbl[i];
      drive(v.rdy, v.rdata, v.stall, v.br, v.tgt);
      #1;
      check_vec(i, v);
      @(negedge clk);
    end

    // imem_ready with no request outstanding sets err
    rst = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("seq_a_err0", 0, {15'd0, err}, 16'd0);
    chk("seq_a_addr", 0, imem_addr, 16'h0000);
    drive(1'b1, 16'h4123, 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    drive(1'b1, 16'h9999, 1'b1, 1'b0, 16'h0000);
    #1;
    chk("seq_a_valid", 0, {15'd0, instr_valid}, 16'd1);
    chk("seq_a_err_pre", 0, {15'd0, err}, 16'd0);
    @(negedge clk);
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    #1;
    chk("seq_a_err_set", 0, {15'd0, err}, 16'd1);
    chk("seq_a_instr", 0, instr_out, 16'h4123);

    // reset in the middle of a pending fetch abandons it
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    #1;
    chk("seq_b_addr", 0, imem_addr, 16'h0002);
    rst = 1'b1;
    drive(1'b1, 16'h3333, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    #1;
    chk("seq_b_req_rst", 0, {15'd0, imem_req}, 16'd0);
    chk("seq_b_err_rst", 0, {15'd0, err}, 16'd0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    rst = 1'b0;
    wait_req(4, "seq_b_req");
    chk("seq_b_addr0", 0, imem_addr, 16'h0000);
    chk("seq_b_err", 0, {15'd0, err}, 16'd0);
    chk("seq_b_valid", 0, {15'd0, instr_valid}, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
